// File: rtl/pt_fetcher.sv
// pt_fetcher: takes single truncated pixels from projective_transform and
// writes them into packed two-pixel SRAM words with a read-modify-write.
// A one-word write-back cache skips the read when consecutive pixels fall
// into the same SRAM word.
module pt_fetcher #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int MEM_W        = 36,
    parameter int PIX_W        = MEM_W / 2,
    parameter int TRUNC_W      = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_flag,
    input  logic                   pt_flag,
    input  logic [WIDTH_BITS-1:0]  pt_x,
    input  logic [HEIGHT_BITS-1:0] pt_y,
    input  logic [TRUNC_W-1:0]     pt_pixel,
    output logic                   done_pt,
    output logic                   ptf_flag,
    output logic                   ptf_wr,
    output logic [WIDTH_BITS-1:0]  ptf_x,
    output logic [HEIGHT_BITS-1:0] ptf_y,
    output logic [MEM_W-1:0]       ptf_pixel_write,
    input  logic                   done_ptf,
    input  logic [MEM_W-1:0]       ptf_pixel_read,
    output logic                   busy
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        WRITE
    } state_t;

    state_t                  state;
    logic [TRUNC_W-1:0]      lat_pixel;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    cache_valid;
    logic [HEIGHT_BITS-1:0]  cache_y;
    logic [WIDTH_BITS-2:0]   cache_xw;
    logic [MEM_W-1:0]        cache_word;
    logic                    cache_hit;

    // Places the truncated pixel (left-justified) into the half of the word
    // selected by the x parity; the other half is carried through unchanged.
    function automatic logic [MEM_W-1:0] merge_pixel(
        input logic [MEM_W-1:0]   word,
        input logic               odd,
        input logic [TRUNC_W-1:0] pix
    );
        logic [PIX_W-1:0] packed_pix;
        logic [MEM_W-1:0] result;
        packed_pix = PIX_W'(pix) << (PIX_W - TRUNC_W);
        result     = word;
        if (odd) begin
            result[PIX_W-1:0] = packed_pix;
        end else begin
            result[MEM_W-1:PIX_W] = packed_pix;
        end
        return result;
    endfunction

    assign cache_hit = cache_valid && (pt_y == cache_y) &&
                       (pt_x[WIDTH_BITS-1:1] == cache_xw);

    // Accept is only offered from IDLE and never while a frame shift is pending.
    assign done_pt = !reset && (state == IDLE) && pt_flag && !frame_flag;

    assign busy = (state != IDLE);

    // Main sequencer: request handshake, read-latency countdown, merge and cache update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            lat_pixel       <= '0;
            wait_cnt        <= '0;
            cache_valid     <= 1'b0;
            cache_y         <= '0;
            cache_xw        <= '0;
            cache_word      <= '0;
            ptf_flag        <= 1'b0;
            ptf_wr          <= 1'b0;
            ptf_x           <= '0;
            ptf_y           <= '0;
            ptf_pixel_write <= '0;
        end else if (frame_flag) begin
            state       <= IDLE;
            cache_valid <= 1'b0;
            ptf_flag    <= 1'b0;
            ptf_wr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pt_flag) begin
                        lat_pixel <= pt_pixel;
                        ptf_x     <= pt_x;
                        ptf_y     <= pt_y;
                        ptf_flag  <= 1'b1;
                        if (cache_hit) begin
                            ptf_wr          <= 1'b1;
                            ptf_pixel_write <= merge_pixel(cache_word, pt_x[0], pt_pixel);
                            state           <= WRITE;
                        end else begin
                            ptf_wr <= 1'b0;
                            state  <= READ;
                        end
                    end
                end
                READ: begin
                    if (done_ptf) begin
                        ptf_flag <= 1'b0;
                        wait_cnt <= CNT_W'(READ_LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        ptf_pixel_write <= merge_pixel(ptf_pixel_read, ptf_x[0], lat_pixel);
                        ptf_flag        <= 1'b1;
                        ptf_wr          <= 1'b1;
                        state           <= WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (done_ptf) begin
                        cache_valid <= 1'b1;
                        cache_y     <= ptf_y;
                        cache_xw    <= ptf_x[WIDTH_BITS-1:1];
                        cache_word  <= ptf_pixel_write;
                        ptf_flag    <= 1'b0;
                        ptf_wr      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pt_fetcher.sv
// tb_pt_fetcher: directed, table-driven bench for pt_fetcher, with a small
// memory responder for the READ_LATENCY=2 instance and a hand-driven
// READ_LATENCY=3 instance for the latency corner case.
module tb_pt_fetcher;

    localparam logic [35:0] GARBAGE = 36'h0F0F0F0F0;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_flag;
    logic        pt_flag;
    logic [9:0]  pt_x;
    logic [8:0]  pt_y;
    logic [11:0] pt_pixel;

    logic        done_pt, ptf_flag, ptf_wr, done_ptf, busy;
    logic [9:0]  ptf_x;
    logic [8:0]  ptf_y;
    logic [35:0] ptf_pixel_write, ptf_pixel_read;

    logic        pt_flag_b, done_pt_b, ptf_flag_b, ptf_wr_b, done_ptf_b, busy_b;
    logic [9:0]  ptf_x_b;
    logic [8:0]  ptf_y_b;
    logic [35:0] ptf_pixel_write_b, ptf_pixel_read_b;

    logic        stall;
    logic [35:0] mem_data;
    int          rd_age;
    int          rd_cnt, wr_cnt;
    logic [9:0]  rd_x, wr_x;
    logic [8:0]  rd_y, wr_y;
    logic [35:0] wr_word;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] pixel;
        logic [35:0] read_data;
        bit          exp_read;
        logic [35:0] exp_word;
    } vector_t;

    vector_t vectors[8];

    pt_fetcher dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag),
        .pt_flag(pt_flag), .pt_x(pt_x), .pt_y(pt_y), .pt_pixel(pt_pixel),
        .done_pt(done_pt), .ptf_flag(ptf_flag), .ptf_wr(ptf_wr),
        .ptf_x(ptf_x), .ptf_y(ptf_y), .ptf_pixel_write(ptf_pixel_write),
        .done_ptf(done_ptf), .ptf_pixel_read(ptf_pixel_read), .busy(busy)
    );

    pt_fetcher #(.READ_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset), .frame_flag(frame_flag),
        .pt_flag(pt_flag_b), .pt_x(pt_x), .pt_y(pt_y), .pt_pixel(pt_pixel),
        .done_pt(done_pt_b), .ptf_flag(ptf_flag_b), .ptf_wr(ptf_wr_b),
        .ptf_x(ptf_x_b), .ptf_y(ptf_y_b), .ptf_pixel_write(ptf_pixel_write_b),
        .done_ptf(done_ptf_b), .ptf_pixel_read(ptf_pixel_read_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    // Memory responder: grants whenever not stalled, returns data exactly two cycles after a read grant.
    assign done_ptf       = ptf_flag && !stall;
    assign ptf_pixel_read = (rd_age == 2) ? mem_data : GARBAGE;

    always @(posedge clock) begin
        if (ptf_flag && done_ptf && !ptf_wr) begin
            rd_age <= 1;
        end else if (rd_age != 0 && rd_age < 100) begin
            rd_age <= rd_age + 1;
        end
    end

    // Transaction monitor: counts granted reads and writes and records their contents.
    always @(posedge clock) begin
        if (ptf_flag && done_ptf) begin
            if (ptf_wr) begin
                wr_cnt  <= wr_cnt + 1;
                wr_word <= ptf_pixel_write;
                wr_x    <= ptf_x;
                wr_y    <= ptf_y;
            end else begin
                rd_cnt <= rd_cnt + 1;
                rd_x   <= ptf_x;
                rd_y   <= ptf_y;
            end
        end
    end

    initial begin
        rd_age = 0;
        rd_cnt = 0;
        wr_cnt = 0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Presents one pixel, waits for the fetcher to return to IDLE, checks the memory traffic.
    task automatic apply_stimulus(input vector_t v, input int exp_cycles);
        int rd0, wr0, n;
        rd0        = rd_cnt;
        wr0        = wr_cnt;
        mem_data   = v.read_data;
        pt_x       = v.x;
        pt_y       = v.y;
        pt_pixel   = v.pixel;
        pt_flag    = 1'b1;
        #1;
        check_output({v.name, " done_pt"}, 64'(done_pt), 64'd1);
        tick();
        pt_flag = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        if (busy) begin
            check_output({v.name, " timeout"}, 64'(busy), 64'd0);
        end
        check_output({v.name, " cycles"}, 64'(n + 1), 64'(exp_cycles));
        check_output({v.name, " reads"}, 64'(rd_cnt - rd0), 64'(v.exp_read));
        check_output({v.name, " writes"}, 64'(wr_cnt - wr0), 64'd1);
        check_output({v.name, " word"}, 64'(wr_word), 64'(v.exp_word));
        check_output({v.name, " wr_xy"}, {32'(wr_x), 32'(wr_y)}, {32'(v.x), 32'(v.y)});
        if (v.exp_read) begin
            check_output({v.name, " rd_xy"}, {32'(rd_x), 32'(rd_y)}, {32'(v.x), 32'(v.y)});
        end
    endtask

    initial begin
        int wr0, rd0, n;
        vector_t v;

        vectors[0] = '{"miss_even",  10'd10,   9'd3,   12'hABC, 36'h123456789, 1'b1, 36'hABC016789};
        vectors[1] = '{"hit_odd",    10'd11,   9'd3,   12'h123, 36'h000000000, 1'b0, 36'hABC0048C0};
        vectors[2] = '{"hit_again",  10'd11,   9'd3,   12'hFFF, 36'h000000000, 1'b0, 36'hABC03FFC0};
        vectors[3] = '{"miss_newy",  10'd10,   9'd4,   12'h001, 36'h000000000, 1'b1, 36'h001000000};
        vectors[4] = '{"miss_neww",  10'd12,   9'd4,   12'h000, 36'hFFFFFFFFF, 1'b1, 36'h00003FFFF};
        vectors[5] = '{"hit_w6",     10'd13,   9'd4,   12'h555, 36'h000000000, 1'b0, 36'h000015540};
        vectors[6] = '{"miss_edge",  10'd1023, 9'd511, 12'hFFF, 36'h800000001, 1'b1, 36'h80003FFC0};
        vectors[7] = '{"hit_edge",   10'd1022, 9'd511, 12'h7FF, 36'h000000000, 1'b0, 36'h7FF03FFC0};

        reset            = 1'b1;
        frame_flag       = 1'b0;
        pt_flag          = 1'b1;
        pt_flag_b        = 1'b0;
        pt_x             = '0;
        pt_y             = '0;
        pt_pixel         = '0;
        stall            = 1'b0;
        mem_data         = '0;
        done_ptf_b       = 1'b0;
        ptf_pixel_read_b = GARBAGE;

        tick();
        tick();
        check_output("reset ptf_flag", 64'(ptf_flag), 64'd0);
        check_output("reset ptf_wr", 64'(ptf_wr), 64'd0);
        check_output("reset done_pt", 64'(done_pt), 64'd0);
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset ptf_pixel_write", 64'(ptf_pixel_write), 64'd0);
        pt_flag = 1'b0;
        reset   = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vectors[i], vectors[i].exp_read ? 5 : 2);
        end

        // Grant withheld for five cycles while in READ.
        $display("[TB] stall in READ");
        stall    = 1'b1;
        mem_data = 36'h000000000;
        pt_x     = 10'd100;
        pt_y     = 9'd7;
        pt_pixel = 12'h0AA;
        pt_flag  = 1'b1;
        #1;
        check_output("stall accept", 64'(done_pt), 64'd1);
        wr0 = wr_cnt;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_output("stall hold", {60'd0, ptf_flag, ptf_wr, done_pt, busy}, 64'b1001);
            check_output("stall xy", {32'(ptf_x), 32'(ptf_y)}, {32'd100, 32'd7});
            tick();
        end
        pt_flag = 1'b0;
        stall   = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        check_output("stall cycles", 64'(n + 6), 64'd10);
        check_output("stall writes", 64'(wr_cnt - wr0), 64'd1);
        check_output("stall word", 64'(wr_word), 64'h0AA000000);

        // Load the cache with the word holding x=10/11, y=3, then abort a different miss in WAIT.
        $display("[TB] frame_flag abort");
        v = '{"load_y3", 10'd10, 9'd3, 12'h111, 36'h000000000, 1'b1, 36'h111000000};
        apply_stimulus(v, 5);
        wr0      = wr_cnt;
        pt_x     = 10'd20;
        pt_y     = 9'd3;
        pt_pixel = 12'h333;
        pt_flag  = 1'b1;
        tick();
        pt_flag = 1'b0;
        tick();
        frame_flag = 1'b1;
        #1;
        check_output("frame blocks accept", 64'(done_pt), 64'd0);
        tick();
        frame_flag = 1'b0;
        check_output("frame idle", {62'd0, busy, ptf_flag}, 64'd0);
        tick();
        tick();
        check_output("frame no write", 64'(wr_cnt - wr0), 64'd0);
        v = '{"after_frame", 10'd11, 9'd3, 12'h222, 36'h123456789, 1'b1, 36'h123448880};
        apply_stimulus(v, 5);

        // READ_LATENCY=3 instance: data valid only at grant+3, garbage at grant+2.
        $display("[TB] latency 3");
        pt_x      = 10'd10;
        pt_y      = 9'd3;
        pt_pixel  = 12'hABC;
        pt_flag_b = 1'b1;
        #1;
        check_output("rl3 accept", 64'(done_pt_b), 64'd1);
        tick();
        pt_flag_b = 1'b0;
        check_output("rl3 read req", {62'd0, ptf_flag_b, ptf_wr_b}, 64'b10);
        done_ptf_b = 1'b1;
        tick();
        done_ptf_b       = 1'b0;
        ptf_pixel_read_b = GARBAGE;
        tick();
        ptf_pixel_read_b = 36'hFFFFFFFFF;
        tick();
        ptf_pixel_read_b = 36'h123456789;
        tick();
        ptf_pixel_read_b = GARBAGE;
        check_output("rl3 write req", {62'd0, ptf_flag_b, ptf_wr_b}, 64'b11);
        check_output("rl3 word", 64'(ptf_pixel_write_b), 64'hABC016789);
        done_ptf_b = 1'b1;
        tick();
        done_ptf_b = 1'b0;
        check_output("rl3 idle", 64'(busy_b), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
